alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages (legal 1..4).
REQ-003 Port clk  input  1  sole clock, all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  operand bundle present.
REQ-006 Port in_ready  output  1  block can accept bundle this cycle.
REQ-007 Port A  input  WIDTH  signed operand A.
REQ-008 Port B  input  WIDTH  signed operand B.
REQ-009 Port opcode  input  3  operation select.
REQ-010 Port out_valid  output  1  result bundle present.
REQ-011 Port out_ready  input  1  consumer accepts result this cycle.
REQ-012 Port Result  output  WIDTH  operation result.
REQ-013 Port Error  output  1  illegal operation flag, qualified by out_valid.
REQ-014 Port Overflow  output  1  signed overflow flag, qualified by out_valid.
REQ-015 Port inflight  output  $clog2(STAGES+1)  count of occupied pipeline stages.

Function
REQ-016 Opcodes SHALL be: 000 ADD, 001 SUB, 010 MUL (low WIDTH bits of signed product), 011 DIV (signed quotient, truncate toward zero), 100 AND, 101 OR, 110 XOR, 111 reserved.
REQ-017 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer on out_valid=1 and out_ready=1.
REQ-018 Each stage SHALL hold a valid bit; a stage loads when it is empty or its contents move downstream in the same cycle (bubbles collapse).
REQ-019 in_ready SHALL be 1 when stage 0 is empty or stage 0 advances this cycle; in_ready SHALL not depend combinationally on in_valid.
REQ-020 With out_ready held 1, latency SHALL be exactly STAGES cycles from input transfer to out_valid, throughput one op per cycle.
REQ-021 With out_ready=0 and out_valid=1, Result/Error/Overflow SHALL hold stable until transfer; no bundle lost, duplicated or reordered.
REQ-022 Full pipeline with out_ready=0 SHALL drive in_ready=0; simultaneous output and input transfer when full SHALL keep inflight unchanged.
REQ-023 inflight SHALL increment on input-only transfer, decrement on output-only transfer, hold on both or neither; range 0..STAGES.
REQ-024 Opcode 111, or DIV with B=0, SHALL set Error=1, Result=0, Overflow=0.
REQ-025 Overflow SHALL be 1 when the exact signed ADD/SUB/MUL result does not fit WIDTH bits, or DIV of -2^(WIDTH-1) by -1; 0 for logic ops.
REQ-026 DIV of -2^(WIDTH-1) by -1 SHALL return -2^(WIDTH-1) (wrap) unless saturation is enabled.
REQ-027 Result/Error/Overflow SHALL be don't-care-free: driven 0 when out_valid=0.

Reset
REQ-028 rst=1 SHALL immediately clear all stage valid bits, discarding in-flight ops.
REQ-029 During and after reset: out_valid=0, Result=0, Error=0, Overflow=0, inflight=0, in_ready=1 from the first edge after rst deasserts.

Configuration
REQ-030 Macro ALU_PIPE_SAT_EN defined: overflowing ADD/SUB/MUL/DIV results SHALL clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1) by true sign; Overflow still asserted.
REQ-031 Macro ALU_PIPE_SAT_EN undefined: overflowing results SHALL wrap modulo 2^WIDTH; no clamping logic present.

Verification
REQ-032 WIDTH=32, STAGES=2: ADD A=5 B=-7, out_ready=1 -> out_valid 2 cycles later, Result=-2, Error=0, Overflow=0.
REQ-033 ADD A=32'h7FFFFFFF B=1 -> Overflow=1; Result=32'h80000000 without ALU_PIPE_SAT_EN, 32'h7FFFFFFF with it.
REQ-034 DIV A=100 B=0, then opcode 111 A=1 B=1 -> both results Error=1, Result=0; DIV A=-7 B=2 -> Result=-3.
REQ-035 Stream 6 back-to-back ops, out_ready=0 for cycles 3-6 -> in_ready falls when inflight=2, results emerge in order, none lost, inflight returns to 0.
REQ-036 Assert rst with inflight=2 mid-stall -> out_valid=0, inflight=0 immediately (asynchronous); next input yields correct result after STAGES cycles.
REQ-037 STAGES=1 and STAGES=4 with random ops/backpressure, scoreboard against reference model -> zero mismatches over 10000 transfers.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU pipeline (ADD/SUB/MUL/DIV/AND/OR/XOR), STAGES register stages.
// Define ALU_PIPE_SAT_EN to clamp overflowing arithmetic results instead of wrapping.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [WIDTH-1:0]          A,
  input  logic signed [WIDTH-1:0]          B,
  input  logic [2:0]                       opcode,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 Result,
  output logic                             Error,
  output logic                             Overflow,
  output logic [$clog2(STAGES+1)-1:0]      inflight
);

  localparam int CW = $clog2(STAGES+1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]          sum_x;
  logic [WIDTH:0]          dif_x;
  logic [2*WIDTH-1:0]      prod_x;
  logic [WIDTH:0]          prod_top;
  logic signed [WIDTH-1:0] div_den;
  logic signed [WIDTH-1:0] quot;
  logic                    div_zero;
  logic                    div_ovf;
  logic [WIDTH-1:0]        res_raw;
  logic [WIDTH-1:0]        res_c;
  logic                    err_c;
  logic                    ovf_c;

  // All arithmetic is evaluated before stage 0; the stages only carry results.
  always_comb begin
    sum_x    = {A[WIDTH-1], A} + {B[WIDTH-1], B};
    dif_x    = {A[WIDTH-1], A} - {B[WIDTH-1], B};
    prod_x   = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    prod_top = prod_x[2*WIDTH-1:WIDTH-1];
    div_zero = (B == '0);
    div_ovf  = (A == MIN_V) && (B == '1);
    div_den  = B;
    if (div_zero || div_ovf) div_den = {{(WIDTH-1){1'b0}}, 1'b1};
    quot     = A / div_den;

    res_raw = '0;
    err_c   = 1'b0;
    ovf_c   = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_raw = sum_x[WIDTH-1:0];
        ovf_c   = sum_x[WIDTH] ^ sum_x[WIDTH-1];
      end
      OP_SUB: begin
        res_raw = dif_x[WIDTH-1:0];
        ovf_c   = dif_x[WIDTH] ^ dif_x[WIDTH-1];
      end
      OP_MUL: begin
        res_raw = prod_x[WIDTH-1:0];
        ovf_c   = !((&prod_top) || (~|prod_top));
      end
      OP_DIV: begin
        if (div_zero) begin
          err_c = 1'b1;
        end else begin
          // min / -1 divides by one instead, leaving the wrapped value -2^(WIDTH-1)
          res_raw = quot;
          ovf_c   = div_ovf;
        end
      end
      OP_AND:  res_raw = A & B;
      OP_OR:   res_raw = A | B;
      OP_XOR:  res_raw = A ^ B;
      default: err_c = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  logic true_neg;

  // Sign of the exact (unbounded) result picks the clamp rail.
  always_comb begin
    true_neg = 1'b0;
    case (opcode)
      OP_ADD:  true_neg = sum_x[WIDTH];
      OP_SUB:  true_neg = dif_x[WIDTH];
      OP_MUL:  true_neg = prod_x[2*WIDTH-1];
      default: true_neg = 1'b0;
    endcase
    res_c = res_raw;
    if (ovf_c) res_c = true_neg ? MIN_V : MAX_V;
  end
`else
  assign res_c = res_raw;
`endif

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;

  // A stage may take new contents when empty or when it drains downstream this cycle.
  always_comb begin
    logic nxt;
    adv = '0;
    nxt = out_ready;
    for (int i = STAGES-1; i >= 0; i--) begin
      adv[i] = !vld[i] || nxt;
      nxt    = adv[i];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             v_q;
    logic             e_q;
    logic             o_q;
    logic [WIDTH-1:0] r_q;
    logic             up_v;
    logic             up_e;
    logic             up_o;
    logic [WIDTH-1:0] up_r;

    if (g == 0) begin : g_head
      assign up_v = in_valid;
      assign up_r = res_c;
      assign up_e = err_c;
      assign up_o = ovf_c;
    end else begin : g_body
      assign up_v = g_stage[g-1].v_q;
      assign up_r = g_stage[g-1].r_q;
      assign up_e = g_stage[g-1].e_q;
      assign up_o = g_stage[g-1].o_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        r_q <= '0;
        e_q <= 1'b0;
        o_q <= 1'b0;
      end else if (adv[g]) begin
        v_q <= up_v;
        if (up_v) begin
          r_q <= up_r;
          e_q <= up_e;
          o_q <= up_o;
        end
      end
    end

    assign vld[g] = v_q;
  end

  logic in_x;
  logic out_x;

  assign in_ready  = adv[0];
  assign out_valid = vld[STAGES-1];
  assign Result    = out_valid ? g_stage[STAGES-1].r_q : '0;
  assign Error     = out_valid && g_stage[STAGES-1].e_q;
  assign Overflow  = out_valid && g_stage[STAGES-1].o_q;

  assign in_x  = in_valid && in_ready;
  assign out_x = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (in_x && !out_x) begin
      inflight <= inflight + CW'(1);
    end else if (!in_x && out_x) begin
      inflight <= inflight - CW'(1);
    end
  end

endmodule
